// File: rtl/rv_pkg.sv
// rv_pkg: shared types and constants for the RV32I instruction-fetch stage
//   fetch_state_e : fetch FSM states
//   INSTR_NOP     : addi x0,x0,0 presented while no instruction has been fetched
//   XLEN          : datapath width
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC} fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory req/ack bus
//   req   : fetch request (master -> slave)
//   addr  : fetch address (master -> slave)
//   ack   : rdata valid this cycle (slave -> master)
//   rdata : fetched instruction word (slave -> master)
interface instr_fetch_if;
  import rv_pkg::*;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_timer.sv
// fetch_timer: counts fetch cycles without ack and flags the last one of a timeout window
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : force the count back to zero (has priority over i_en)
//   i_en           : count this cycle
//   o_expire       : counting and the count has reached TIMEOUT_CYC-1
module fetch_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_expire = i_en && cnt_q == LAST;
  assign cnt_d = i_clr ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage - PC register, next-PC mux and req/ack fetch FSM
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_pc_sel, i_alu_data   : take ALU target as next PC / the target itself
//   i_stall                : hold the EXEC slot
//   imem (master)          : instruction-memory req/addr/ack/rdata bus
//   o_instr, o_instr_vld   : instruction to decode and its valid
//   o_pc, o_pc_four        : PC of o_instr and PC+4
//   o_fetch_err            : pulse on each fetch timeout
//   o_misalign             : pulse on a misaligned target
// Optional feature: define IFU_MISALIGN_CHECK_EN to redirect targets with bit 1 set to TRAP_PC.
module instr_fetch import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC     = 32'h0000_0100,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_stall,
  instr_fetch_if.master   imem,
  output logic [XLEN-1:0] o_instr,
  output logic            o_instr_vld,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four,
  output logic            o_fetch_err,
  output logic            o_misalign
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, target;
  logic in_fetch, in_exec, expire, misalign, unused_bits;
  assign in_fetch = state_q == S_FETCH;
  assign in_exec = state_q == S_EXEC;
`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = i_pc_sel & i_alu_data[1];
  assign target = misalign ? TRAP_PC : {i_alu_data[XLEN-1:1], 1'b0};
  assign unused_bits = i_alu_data[0];
`else
  assign misalign = 1'b0;
  assign target = {i_alu_data[XLEN-1:2], 2'b00};
  assign unused_bits = ^{i_alu_data[1:0], TRAP_PC};
`endif
  // Held at zero outside FETCH so every fetch starts a fresh window; an ack ends the window.
  fetch_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (!in_fetch || imem.ack || expire),
    .i_en     (in_fetch),
    .o_expire (expire)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (imem.ack) begin
        instr_d = imem.rdata;
        state_d = S_EXEC;
      end
      S_EXEC: if (!i_stall) begin
        pc_d = i_pc_sel ? target : pc_q + XLEN'(4);
        state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_RESET;
      pc_q <= RESET_PC;
      instr_q <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  assign imem.req = in_fetch;
  assign imem.addr = pc_q;
  assign o_instr = instr_q;
  assign o_instr_vld = in_exec;
  assign o_pc = pc_q;
  assign o_pc_four = pc_q + XLEN'(4);
  assign o_fetch_err = expire & ~imem.ack;
  assign o_misalign = in_exec & ~i_stall & misalign;
endmodule
